ddr4_cmd_decoder: RTL and testbench

DDR4_CMD_DECODER -- requirements
Module: ddr4_cmd_decoder

---
 rtl/ddr4_cmd_decoder.sv | 279 +++++++++++++++++++++++++++
 tb/tb_ddr4_cmd_decoder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ddr4_cmd_decoder.sv
// DDR4 command-bus decoder: registers the pins, decodes one command per cycle,
// tracks per-bank open/idle state and tRCD/tRP spacing, and generates data windows.
module ddr4_cmd_decoder #(
  parameter int NUMRANK       = 1,
  parameter int BGWIDTH       = 2,
  parameter int BKWIDTH       = 2,
  parameter int COMMAND_WIDTH = 17,
  parameter int ROWWIDTH      = 15,
  parameter int COLWIDTH      = 10,
  parameter int TRCD          = 4,
  parameter int TRP           = 4,
  parameter int CL            = 6,
  parameter int CWL           = 5,
  parameter int BURST_CYCLES  = 4,
  localparam int RANKW        = (NUMRANK > 1) ? $clog2(NUMRANK) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cke,
  input  logic [NUMRANK-1:0]       cs_n,
  input  logic                     act_n,
  input  logic [BGWIDTH-1:0]       bg,
  input  logic [BKWIDTH-1:0]       b,
  input  logic [COMMAND_WIDTH-1:0] pin_A,
  output logic                     cmd_valid,
  output logic [2:0]               cmd_type,
  output logic [RANKW-1:0]         cmd_rank,
  output logic [BGWIDTH-1:0]       cmd_bg,
  output logic [BKWIDTH-1:0]       cmd_bk,
  output logic [ROWWIDTH-1:0]      cmd_row,
  output logic [COLWIDTH-1:0]      cmd_col,
  output logic                     cmd_ap,
  output logic                     err_illegal,
  output logic                     err_timing,
  output logic                     rd_dq_en,
  output logic                     wr_dq_en
);

  localparam int unsigned BPR  = 1 << (BGWIDTH + BKWIDTH);
  localparam int unsigned NB   = NUMRANK * BPR;
  localparam int unsigned IDXW = (NB > 1) ? $clog2(NB) : 1;
  localparam int          MAXT = (TRCD > TRP) ? TRCD : TRP;
  localparam int          CNTW = (MAXT > 0) ? $clog2(MAXT + 1) : 1;
  localparam int          RDSR = CL + BURST_CYCLES - 1;
  localparam int          WRSR = CWL + BURST_CYCLES - 1;
  localparam int          RAS_BIT = 16;
  localparam int          CAS_BIT = 15;
  localparam int          WE_BIT  = 14;
  localparam int          AP_BIT  = 10;
  localparam logic [CNTW-1:0] CNT_SAT = CNTW'(MAXT);

  typedef enum logic {BANK_IDLE, BANK_ACTIVE} bank_state_e;
  typedef enum logic [2:0] {
    CMD_NOP = 3'd0, CMD_ACT = 3'd1, CMD_RD  = 3'd2, CMD_WR    = 3'd3,
    CMD_PRE = 3'd4, CMD_REF = 3'd5, CMD_DES = 3'd6, CMD_OTHER = 3'd7
  } cmd_e;

  // Pin capture stage
  logic                     p_cke_q;
  logic [NUMRANK-1:0]       p_cs_n_q;
  logic                     p_act_n_q;
  logic [BGWIDTH-1:0]       p_bg_q;
  logic [BKWIDTH-1:0]       p_b_q;
  logic [COMMAND_WIDTH-1:0] p_a_q;

  bank_state_e         bank_q [NB];
  bank_state_e         bank_d [NB];
  logic [ROWWIDTH-1:0] row_q  [NB];
  logic [ROWWIDTH-1:0] row_d  [NB];
  logic [CNTW-1:0]     cnt_q  [NB];
  logic [CNTW-1:0]     cnt_d  [NB];

  logic                cmd_valid_q, cmd_valid_d;
  cmd_e                cmd_type_q, cmd_type_d;
  logic [RANKW-1:0]    cmd_rank_q, cmd_rank_d;
  logic [BGWIDTH-1:0]  cmd_bg_q, cmd_bg_d;
  logic [BKWIDTH-1:0]  cmd_bk_q, cmd_bk_d;
  logic [ROWWIDTH-1:0] cmd_row_q, cmd_row_d;
  logic [COLWIDTH-1:0] cmd_col_q, cmd_col_d;
  logic                cmd_ap_q, cmd_ap_d;
  logic                err_illegal_q, err_illegal_d;
  logic                err_timing_q, err_timing_d;
  logic [RDSR-1:0]     rd_sr_q, rd_sr_d;
  logic [WRSR-1:0]     wr_sr_q, wr_sr_d;
  logic                rd_dq_en_q, rd_dq_en_d;
  logic                wr_dq_en_q, wr_dq_en_d;

  int unsigned         n_low;
  int unsigned         base;
  int unsigned         loc;
  logic [RANKW-1:0]    sel_rank;
  logic [IDXW-1:0]     bidx;
  logic [IDXW-1:0]     jidx;
  logic                rank_busy;
  logic                hit_active;
  int                  elapsed;
  logic                ras, cas, we, ap;
  logic                rd_hit, wr_hit;

  always_comb begin
    bank_d = bank_q;
    row_d  = row_q;
    for (int unsigned i = 0; i < NB; i++)
      cnt_d[i] = (cnt_q[i] == CNT_SAT) ? cnt_q[i] : cnt_q[i] + CNTW'(1);

    n_low    = 0;
    sel_rank = '0;
    for (int unsigned r = 0; r < NUMRANK; r++) begin
      if (!p_cs_n_q[r]) begin
        n_low++;
        sel_rank = RANKW'(r);
      end
    end
    base = 32'(sel_rank) * BPR;
    loc  = 32'({p_bg_q, p_b_q});
    bidx = IDXW'(base + loc);
    jidx = '0;

    rank_busy = 1'b0;
    for (int unsigned j = 0; j < BPR; j++)
      if (bank_q[IDXW'(base + j)] == BANK_ACTIVE) rank_busy = 1'b1;
    hit_active = (bank_q[bidx] == BANK_ACTIVE);
    // Counter is zeroed at the edge that processes the reference command,
    // so cycles between the two pin samples is count + 1.
    elapsed = int'(cnt_q[bidx]) + 1;

    ras = p_a_q[RAS_BIT];
    cas = p_a_q[CAS_BIT];
    we  = p_a_q[WE_BIT];
    ap  = p_a_q[AP_BIT];

    cmd_valid_d   = 1'b0;
    cmd_type_d    = CMD_NOP;
    err_illegal_d = 1'b0;
    err_timing_d  = 1'b0;
    rd_hit        = 1'b0;
    wr_hit        = 1'b0;
    cmd_rank_d    = sel_rank;
    cmd_bg_d      = p_bg_q;
    cmd_bk_d      = p_b_q;
    cmd_row_d     = p_a_q[ROWWIDTH-1:0];
    cmd_col_d     = p_a_q[COLWIDTH-1:0];
    cmd_ap_d      = ap;

    if (p_cke_q) begin
      if (n_low == 0) begin
        cmd_type_d = CMD_DES;
      end else if (n_low > 1) begin
        cmd_type_d    = CMD_OTHER;
        cmd_valid_d   = 1'b1;
        err_illegal_d = 1'b1;
      end else if (!p_act_n_q) begin
        cmd_type_d  = CMD_ACT;
        cmd_valid_d = 1'b1;
        if (hit_active) begin
          err_illegal_d = 1'b1;
        end else begin
          err_timing_d = (elapsed < TRP);
          bank_d[bidx] = BANK_ACTIVE;
          row_d[bidx]  = p_a_q[ROWWIDTH-1:0];
          cnt_d[bidx]  = '0;
        end
      end else begin
        case ({ras, cas, we})
          3'b010, 3'b011: begin
            cmd_type_d  = we ? CMD_WR : CMD_RD;
            cmd_valid_d = 1'b1;
            rd_hit      = !we;
            wr_hit      = we;
            if (!hit_active) begin
              err_illegal_d = 1'b1;
            end else begin
              err_timing_d = (elapsed < TRCD);
              if (ap) begin
                bank_d[bidx] = BANK_IDLE;
                cnt_d[bidx]  = '0;
              end
            end
          end
          3'b001: begin
            cmd_type_d  = CMD_PRE;
            cmd_valid_d = 1'b1;
            for (int unsigned j = 0; j < BPR; j++) begin
              jidx = IDXW'(base + j);
              if ((ap || (j == loc)) && (bank_q[jidx] == BANK_ACTIVE)) begin
                bank_d[jidx] = BANK_IDLE;
                cnt_d[jidx]  = '0;
              end
            end
          end
          3'b000: begin
            cmd_type_d    = CMD_REF;
            cmd_valid_d   = 1'b1;
            err_illegal_d = rank_busy;
          end
          3'b111: cmd_type_d = CMD_NOP;
          default: begin
            cmd_type_d  = CMD_OTHER;
            cmd_valid_d = 1'b1;
          end
        endcase
      end
    end

    // Bit j of a shift register marks a strobe j+1 edges before the next edge
    rd_sr_d    = (rd_sr_q << 1) | RDSR'(rd_hit);
    wr_sr_d    = (wr_sr_q << 1) | WRSR'(wr_hit);
    rd_dq_en_d = |rd_sr_q[RDSR-1 -: BURST_CYCLES];
    wr_dq_en_d = |wr_sr_q[WRSR-1 -: BURST_CYCLES];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_cke_q       <= 1'b0;
      p_cs_n_q      <= '1;
      p_act_n_q     <= 1'b1;
      p_bg_q        <= '0;
      p_b_q         <= '0;
      p_a_q         <= '0;
      for (int unsigned i = 0; i < NB; i++) begin
        bank_q[i] <= BANK_IDLE;
        row_q[i]  <= '0;
        cnt_q[i]  <= CNT_SAT;
      end
      cmd_valid_q   <= 1'b0;
      cmd_type_q    <= CMD_NOP;
      cmd_rank_q    <= '0;
      cmd_bg_q      <= '0;
      cmd_bk_q      <= '0;
      cmd_row_q     <= '0;
      cmd_col_q     <= '0;
      cmd_ap_q      <= 1'b0;
      err_illegal_q <= 1'b0;
      err_timing_q  <= 1'b0;
      rd_sr_q       <= '0;
      wr_sr_q       <= '0;
      rd_dq_en_q    <= 1'b0;
      wr_dq_en_q    <= 1'b0;
    end else begin
      p_cke_q       <= cke;
      p_cs_n_q      <= cs_n;
      p_act_n_q     <= act_n;
      p_bg_q        <= bg;
      p_b_q         <= b;
      p_a_q         <= pin_A;
      bank_q        <= bank_d;
      row_q         <= row_d;
      cnt_q         <= cnt_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_type_q    <= cmd_type_d;
      cmd_rank_q    <= cmd_rank_d;
      cmd_bg_q      <= cmd_bg_d;
      cmd_bk_q      <= cmd_bk_d;
      cmd_row_q     <= cmd_row_d;
      cmd_col_q     <= cmd_col_d;
      cmd_ap_q      <= cmd_ap_d;
      err_illegal_q <= err_illegal_d;
      err_timing_q  <= err_timing_d;
      rd_sr_q       <= rd_sr_d;
      wr_sr_q       <= wr_sr_d;
      rd_dq_en_q    <= rd_dq_en_d;
      wr_dq_en_q    <= wr_dq_en_d;
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_type    = cmd_type_q;
  assign cmd_rank    = cmd_rank_q;
  assign cmd_bg      = cmd_bg_q;
  assign cmd_bk      = cmd_bk_q;
  assign cmd_row     = cmd_row_q;
  assign cmd_col     = cmd_col_q;
  assign cmd_ap      = cmd_ap_q;
  assign err_illegal = err_illegal_q;
  assign err_timing  = err_timing_q;
  assign rd_dq_en    = rd_dq_en_q;
  assign wr_dq_en    = wr_dq_en_q;

endmodule

// File: tb/tb_ddr4_cmd_decoder.sv
// Directed bench for ddr4_cmd_decoder (two ranks): decode, bank protocol,
// tRCD/tRP spacing, data windows and reset behaviour.
module tb_ddr4_cmd_decoder;

  localparam logic [16:0] A_RD  = 17'h08000;
  localparam logic [16:0] A_WR  = 17'h0C000;
  localparam logic [16:0] A_PRE = 17'h04000;
  localparam logic [16:0] A_REF = 17'h00000;
  localparam logic [16:0] A_NOP = 17'h1C000;
  localparam logic [16:0] A_AP  = 17'h00400;

  logic        clk = 1'b0;
  logic        rst, cke, act_n;
  logic [1:0]  cs_n, bg, b;
  logic [16:0] pin_A;
  logic        cmd_valid, cmd_ap, err_illegal, err_timing, rd_dq_en, wr_dq_en;
  logic [2:0]  cmd_type;
  logic [0:0]  cmd_rank;
  logic [1:0]  cmd_bg, cmd_bk;
  logic [14:0] cmd_row;
  logic [9:0]  cmd_col;

  int checks = 0;
  int errors = 0;

  ddr4_cmd_decoder #(.NUMRANK(2)) dut (
    .clk(clk), .rst(rst), .cke(cke), .cs_n(cs_n), .act_n(act_n), .bg(bg), .b(b),
    .pin_A(pin_A), .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_rank(cmd_rank),
    .cmd_bg(cmd_bg), .cmd_bk(cmd_bk), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .cmd_ap(cmd_ap), .err_illegal(err_illegal), .err_timing(err_timing),
    .rd_dq_en(rd_dq_en), .wr_dq_en(wr_dq_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) step();
  endtask

  task automatic set_idle();
    cke   = 1'b1;
    cs_n  = 2'b11;
    act_n = 1'b1;
    pin_A = A_NOP;
  endtask

  // Pins sampled at the first edge; decoded outputs are observed after the second.
  task automatic issue(input logic k, input logic [1:0] cs, input logic an,
                       input logic [1:0] g, input logic [1:0] bk, input logic [16:0] a);
    cke = k; cs_n = cs; act_n = an; bg = g; b = bk; pin_A = a;
    step();
    set_idle();
    step();
  endtask

  task automatic chk_err(input string tag, input logic il, input logic tm);
    chk({tag, "_illegal"}, 32'(err_illegal), 32'(il));
    chk({tag, "_timing"}, 32'(err_timing), 32'(tm));
  endtask

  initial begin
    rst = 1'b1; bg = '0; b = '0;
    set_idle();
    gap(3);
    chk("rst_valid", 32'(cmd_valid), 0);
    chk("rst_type", 32'(cmd_type), 0);
    chk_err("rst", 1'b0, 1'b0);
    chk("rst_rd_en", 32'(rd_dq_en), 0);
    chk("rst_wr_en", 32'(wr_dq_en), 0);
    chk("rst_row", 32'(cmd_row), 0);
    rst = 1'b0;
    gap(2);
    chk("des_type", 32'(cmd_type), 6);
    chk("des_valid", 32'(cmd_valid), 0);

    // ACT then RD exactly tRCD later, read window
    issue(1'b1, 2'b10, 1'b0, 2'd1, 2'd2, 17'h01234);
    chk("act_type", 32'(cmd_type), 1);
    chk("act_valid", 32'(cmd_valid), 1);
    chk("act_rank", 32'(cmd_rank), 0);
    chk("act_bg", 32'(cmd_bg), 1);
    chk("act_bk", 32'(cmd_bk), 2);
    chk("act_row", 32'(cmd_row), 32'h1234);
    chk_err("act", 1'b0, 1'b0);
    gap(2);
    issue(1'b1, 2'b10, 1'b1, 2'd1, 2'd2, A_RD | 17'h00008);
    chk("rd_type", 32'(cmd_type), 2);
    chk("rd_valid", 32'(cmd_valid), 1);
    chk("rd_col", 32'(cmd_col), 8);
    chk("rd_ap", 32'(cmd_ap), 0);
    chk_err("rd", 1'b0, 1'b0);
    chk("rd_win0", 32'(rd_dq_en), 0);
    for (int i = 1; i <= 11; i++) begin
      step();
      chk($sformatf("rd_win%0d", i), 32'(rd_dq_en), (i >= 6 && i <= 9) ? 1 : 0);
    end

    // RD to idle bank, then double ACT
    issue(1'b1, 2'b10, 1'b1, 2'd3, 2'd3, A_RD);
    chk("rd_idle_type", 32'(cmd_type), 2);
    chk_err("rd_idle", 1'b1, 1'b0);
    issue(1'b1, 2'b10, 1'b0, 2'd3, 2'd3, 17'h00005);
    chk_err("act_first", 1'b0, 1'b0);
    gap(2);
    issue(1'b1, 2'b10, 1'b0, 2'd3, 2'd3, 17'h00005);
    chk("act_twice_valid", 32'(cmd_valid), 1);
    chk("act_twice_illegal", 32'(err_illegal), 1);

    // RD three cycles after ACT violates tRCD; bank still active
    issue(1'b1, 2'b10, 1'b0, 2'd0, 2'd0, 17'h00077);
    gap(1);
    issue(1'b1, 2'b10, 1'b1, 2'd0, 2'd0, A_RD);
    chk_err("rd_trcd", 1'b0, 1'b1);
    gap(2);
    issue(1'b1, 2'b10, 1'b0, 2'd0, 2'd0, 17'h00077);
    chk("act_still_active", 32'(err_illegal), 1);

    // WR with auto-precharge, then ACT at 3 (tRP violation) and at 4 (clean)
    issue(1'b1, 2'b10, 1'b0, 2'd2, 2'd1, 17'h00100);
    gap(2);
    issue(1'b1, 2'b10, 1'b1, 2'd2, 2'd1, A_WR | A_AP);
    chk("wr_type", 32'(cmd_type), 3);
    chk("wr_ap", 32'(cmd_ap), 1);
    chk_err("wr_ap", 1'b0, 1'b0);
    gap(1);
    issue(1'b1, 2'b10, 1'b0, 2'd2, 2'd1, 17'h00100);
    chk_err("act_trp3", 1'b0, 1'b1);
    chk("wr_win3", 32'(wr_dq_en), 0);
    gap(2);
    issue(1'b1, 2'b10, 1'b1, 2'd2, 2'd1, A_WR | A_AP);
    chk_err("wr_ap2", 1'b0, 1'b0);
    chk("wr_win7", 32'(wr_dq_en), 1);
    gap(2);
    issue(1'b1, 2'b10, 1'b0, 2'd2, 2'd1, 17'h00100);
    chk_err("act_trp4", 1'b0, 1'b0);

    // REF with open banks, precharge-all, REF again
    issue(1'b1, 2'b10, 1'b1, 2'd0, 2'd0, A_REF);
    chk("ref_busy_type", 32'(cmd_type), 5);
    chk_err("ref_busy", 1'b1, 1'b0);
    issue(1'b1, 2'b10, 1'b1, 2'd0, 2'd0, A_PRE | A_AP);
    chk("pre_all_type", 32'(cmd_type), 4);
    chk_err("pre_all", 1'b0, 1'b0);
    issue(1'b1, 2'b10, 1'b1, 2'd0, 2'd0, A_REF);
    chk("ref_clean_valid", 32'(cmd_valid), 1);
    chk_err("ref_clean", 1'b0, 1'b0);
    issue(1'b1, 2'b10, 1'b1, 2'd0, 2'd0, A_PRE);
    chk_err("pre_idle", 1'b0, 1'b0);

    // cke low, multiple chip selects, rank 1, NOP
    issue(1'b0, 2'b10, 1'b0, 2'd0, 2'd1, 17'h00042);
    chk("cke0_valid", 32'(cmd_valid), 0);
    chk_err("cke0", 1'b0, 1'b0);
    issue(1'b1, 2'b10, 1'b0, 2'd0, 2'd1, 17'h00042);
    chk("cke0_unchanged", 32'(err_illegal), 0);
    issue(1'b1, 2'b00, 1'b0, 2'd1, 2'd1, 17'h00011);
    chk("multi_cs_type", 32'(cmd_type), 7);
    chk("multi_cs_valid", 32'(cmd_valid), 1);
    chk("multi_cs_illegal", 32'(err_illegal), 1);
    issue(1'b1, 2'b10, 1'b0, 2'd1, 2'd1, 17'h00011);
    chk("multi_cs_unchanged", 32'(err_illegal), 0);
    issue(1'b1, 2'b01, 1'b0, 2'd1, 2'd2, 17'h00033);
    chk("rank1_rank", 32'(cmd_rank), 1);
    chk_err("rank1", 1'b0, 1'b0);
    issue(1'b1, 2'b10, 1'b1, 2'd0, 2'd0, A_NOP);
    chk("nop_type", 32'(cmd_type), 0);
    chk("nop_valid", 32'(cmd_valid), 0);

    // Reset in the middle of a read window
    issue(1'b1, 2'b10, 1'b1, 2'd0, 2'd1, A_RD);
    gap(6);
    chk("rst_win_before", 32'(rd_dq_en), 1);
    rst = 1'b1;
    step();
    chk("rst_win_drop", 32'(rd_dq_en), 0);
    chk("rst_win_valid", 32'(cmd_valid), 0);
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk($sformatf("rst_win_after%0d", i), 32'(rd_dq_en), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
